// File: rtl/e603_subsys_misc_icb_buf.sv
// rtl/e603_subsys_misc_icb_buf.sv - window/alignment-checking ICB buffer in front of the misc register block
// Optional downstream response timeout: define E603_MISC_ICB_BUF_TMO_EN.
module e603_subsys_misc_icb_buf #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter logic [15:0] TMO_CYCLES = 16'd1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_icb_cmd_valid,
  output logic                 i_icb_cmd_ready,
  input  logic [31:0]          i_icb_cmd_addr,
  input  logic                 i_icb_cmd_read,
  input  logic [31:0]          i_icb_cmd_wdata,
  input  logic [3:0]           i_icb_cmd_wmask,
  output logic                 i_icb_rsp_valid,
  input  logic                 i_icb_rsp_ready,
  output logic [31:0]          i_icb_rsp_rdata,
  output logic                 i_icb_rsp_err,
  output logic                 o_icb_cmd_valid,
  input  logic                 o_icb_cmd_ready,
  output logic [11:0]          o_icb_cmd_addr,
  output logic                 o_icb_cmd_read,
  output logic [31:0]          o_icb_cmd_wdata,
  input  logic                 o_icb_rsp_valid,
  output logic                 o_icb_rsp_ready,
  input  logic [31:0]          o_icb_rsp_rdata,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RSP} state_t;

  state_t      state_q, state_d;
  logic [11:0] addr_q,  addr_d;
  logic        read_q,  read_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;
  logic        cmd_legal;
  logic        dn_cmd_hs;
  logic        dn_rsp_hs;
  logic        up_rsp_hs;

  if (BASE_ADDR[11:0] != 12'h000) begin : g_base_unaligned
    $error("BASE_ADDR must be 4 KB aligned");
  end
  if (TMO_CYCLES == 16'd0) begin : g_tmo_zero
    $error("TMO_CYCLES must be non-zero");
  end

`ifdef E603_MISC_ICB_BUF_TMO_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        drop_pend_q, drop_pend_d;
`endif

  assign cmd_legal = (i_icb_cmd_addr[31:12] == BASE_ADDR[31:12]) &&
                     (i_icb_cmd_addr[1:0] == 2'b00) &&
                     (i_icb_cmd_read || (i_icb_cmd_wmask == 4'hF));

  assign dn_cmd_hs = o_icb_cmd_valid & o_icb_cmd_ready;
  assign dn_rsp_hs = o_icb_rsp_valid & o_icb_rsp_ready;
  assign up_rsp_hs = i_icb_rsp_valid & i_icb_rsp_ready;

  assign o_icb_cmd_addr  = addr_q;
  assign o_icb_cmd_read  = read_q;
  assign o_icb_cmd_wdata = wdata_q;
  assign i_icb_rsp_rdata = rdata_q;
  assign i_icb_rsp_err   = err_q;

  // Handshake outputs decode from registered state only; the misc slave ties
  // its cmd_ready to our rsp_ready, so rsp_ready must not look at cmd_ready.
  always_comb begin
    i_icb_cmd_ready = (state_q == IDLE);
    i_icb_rsp_valid = (state_q == RSP);
    o_icb_cmd_valid = (state_q == CMD);
    o_icb_rsp_ready = (state_q == CMD) || (state_q == WAIT);
`ifdef E603_MISC_ICB_BUF_TMO_EN
    if (drop_pend_q) begin
      o_icb_cmd_valid = 1'b0;
      o_icb_rsp_ready = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    read_d  = read_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (i_icb_cmd_valid) begin
          if (cmd_legal) begin
            addr_d  = i_icb_cmd_addr[11:0];
            read_d  = i_icb_cmd_read;
            wdata_d = i_icb_cmd_wdata;
            state_d = CMD;
          end else begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = RSP;
          end
        end
      end
      CMD: begin
        if (dn_cmd_hs) begin
          if (dn_rsp_hs) begin
            rdata_d = read_q ? o_icb_rsp_rdata : 32'h0;
            err_d   = 1'b0;
            state_d = RSP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dn_rsp_hs) begin
          rdata_d = read_q ? o_icb_rsp_rdata : 32'h0;
          err_d   = 1'b0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (i_icb_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef E603_MISC_ICB_BUF_TMO_EN
    tmo_cnt_d   = 16'h0;
    drop_pend_d = drop_pend_q;
    if (drop_pend_q && o_icb_rsp_valid) drop_pend_d = 1'b0;
    // The counter only runs while a command is actually visible downstream.
    if (((state_q == CMD) || (state_q == WAIT)) && !drop_pend_q) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
      if ((tmo_cnt_q == TMO_CYCLES - 16'd1) && (state_d != RSP)) begin
        state_d     = RSP;
        rdata_d     = 32'h0;
        err_d       = 1'b1;
        tmo_cnt_d   = 16'h0;
        drop_pend_d = (state_q == WAIT) || dn_cmd_hs;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 12'h0;
      read_q  <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef E603_MISC_ICB_BUF_TMO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q   <= 16'h0;
      drop_pend_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      drop_pend_q <= drop_pend_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (up_rsp_hs && err_q && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_e603_subsys_misc_icb_buf.sv
// tb/tb_e603_subsys_misc_icb_buf.sv - scoreboard bench for e603_subsys_misc_icb_buf
module tb_e603_subsys_misc_icb_buf;

  localparam int ERR_CNT_W = 8;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_icb_cmd_valid;
  logic                 i_icb_cmd_ready;
  logic [31:0]          i_icb_cmd_addr;
  logic                 i_icb_cmd_read;
  logic [31:0]          i_icb_cmd_wdata;
  logic [3:0]           i_icb_cmd_wmask;
  logic                 i_icb_rsp_valid;
  logic                 i_icb_rsp_ready;
  logic [31:0]          i_icb_rsp_rdata;
  logic                 i_icb_rsp_err;
  logic                 o_icb_cmd_valid;
  logic                 o_icb_cmd_ready;
  logic [11:0]          o_icb_cmd_addr;
  logic                 o_icb_cmd_read;
  logic [31:0]          o_icb_cmd_wdata;
  logic                 o_icb_rsp_valid;
  logic                 o_icb_rsp_ready;
  logic [31:0]          o_icb_rsp_rdata;
  logic [ERR_CNT_W-1:0] err_cnt;

  // Misc slave model: cmd_ready tied to rsp_ready, optional combinational response.
  logic        slv_rdy_en;
  logic        slv_comb;
  logic        slv_stray;
  logic [31:0] slv_rdata;

  assign o_icb_cmd_ready = slv_rdy_en & o_icb_rsp_ready;
  assign o_icb_rsp_valid = (slv_comb & o_icb_cmd_valid & o_icb_cmd_ready) | slv_stray;
  assign o_icb_rsp_rdata = slv_rdata;

  e603_subsys_misc_icb_buf #(
    .BASE_ADDR  (32'h1001_0000),
    .ERR_CNT_W  (ERR_CNT_W),
    .TMO_CYCLES (16'd8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_icb_cmd_valid (i_icb_cmd_valid),
    .i_icb_cmd_ready (i_icb_cmd_ready),
    .i_icb_cmd_addr  (i_icb_cmd_addr),
    .i_icb_cmd_read  (i_icb_cmd_read),
    .i_icb_cmd_wdata (i_icb_cmd_wdata),
    .i_icb_cmd_wmask (i_icb_cmd_wmask),
    .i_icb_rsp_valid (i_icb_rsp_valid),
    .i_icb_rsp_ready (i_icb_rsp_ready),
    .i_icb_rsp_rdata (i_icb_rsp_rdata),
    .i_icb_rsp_err   (i_icb_rsp_err),
    .o_icb_cmd_valid (o_icb_cmd_valid),
    .o_icb_cmd_ready (o_icb_cmd_ready),
    .o_icb_cmd_addr  (o_icb_cmd_addr),
    .o_icb_cmd_read  (o_icb_cmd_read),
    .o_icb_cmd_wdata (o_icb_cmd_wdata),
    .o_icb_rsp_valid (o_icb_rsp_valid),
    .o_icb_rsp_ready (o_icb_rsp_ready),
    .o_icb_rsp_rdata (o_icb_rsp_rdata),
    .err_cnt         (err_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_err_cnt = 0;
  int          dn_cnt = 0;
  int          cmd_valid_cyc = 0;
  logic [32:0] up_q[$];
  logic [44:0] dn_q[$];
  logic [32:0] up_exp;
  logic [44:0] dn_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_icb_cmd_valid) cmd_valid_cyc++;
      if (o_icb_cmd_valid && o_icb_cmd_ready) begin
        dn_cnt++;
        chk("dn_expected", dn_q.size() != 0, 1'b1);
        if (dn_q.size() != 0) begin
          dn_exp = dn_q.pop_front();
          chk("dn_cmd", {o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata}, dn_exp);
        end
      end
      if (i_icb_rsp_valid && i_icb_rsp_ready) begin
        chk("up_expected", up_q.size() != 0, 1'b1);
        if (up_q.size() != 0) begin
          up_exp = up_q.pop_front();
          chk("up_rsp", {i_icb_rsp_err, i_icb_rsp_rdata}, up_exp);
        end
      end
    end
  end

  task automatic send(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                      input logic [3:0] wm, input logic [31:0] rdv, input logic exp_err);
    int n;
    slv_rdata = rdv;
    if (exp_err) begin
      up_q.push_back({1'b1, 32'h0});
      if (exp_err_cnt < ERR_MAX) exp_err_cnt++;
    end else begin
      up_q.push_back({1'b0, rd ? rdv : 32'h0});
      dn_q.push_back({addr[11:0], rd, wd});
    end
    i_icb_cmd_valid = 1'b1;
    i_icb_cmd_addr  = addr;
    i_icb_cmd_read  = rd;
    i_icb_cmd_wdata = wd;
    i_icb_cmd_wmask = wm;
    n = 0;
    @(negedge clk);
    while (!i_icb_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", i_icb_cmd_ready, 1'b1);
    tick();
    i_icb_cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((up_q.size() != 0 || !i_icb_cmd_ready) && n < 100) begin
      tick();
      n++;
    end
    chk("done_in_time", n < 100, 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    i_icb_cmd_valid = 1'b0;
    i_icb_cmd_addr  = 32'h0;
    i_icb_cmd_read  = 1'b0;
    i_icb_cmd_wdata = 32'h0;
    i_icb_cmd_wmask = 4'h0;
    i_icb_rsp_ready = 1'b1;
    slv_rdy_en = 1'b1;
    slv_comb   = 1'b1;
    slv_stray  = 1'b0;
    slv_rdata  = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", i_icb_cmd_ready, 1'b1);
    chk("rst_rsp_valid", i_icb_rsp_valid, 1'b0);
    chk("rst_dn_cmd_valid", o_icb_cmd_valid, 1'b0);
    chk("rst_dn_rsp_ready", o_icb_rsp_ready, 1'b0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_rdata_err", {i_icb_rsp_err, i_icb_rsp_rdata}, 33'h0);
    chk("rst_dn_fields", {o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata}, 45'h0);
    tick();
    rst_n = 1'b1;

    // Read with combinational misc response: rsp two cycles after accept.
    send(32'h1001_0F00, 1'b1, 32'h0, 4'h0, 32'h0001_0400, 1'b0);
    @(negedge clk);
    chk("lat_n1_rsp_valid", i_icb_rsp_valid, 1'b0);
    chk("lat_n1_dn_valid", o_icb_cmd_valid, 1'b1);
    chk("lat_n1_dn_addr", o_icb_cmd_addr, 12'hF00);
    @(negedge clk);
    chk("lat_n2_rsp_valid", i_icb_rsp_valid, 1'b1);
    wait_done();

    // Full-word write; response rdata must be zero.
    send(32'h1001_0004, 1'b0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0);
    wait_done();

    // Out of window, partial write mask, misaligned.
    base = cmd_valid_cyc;
    send(32'h1002_0000, 1'b1, 32'h0, 4'h0, 32'h1111_1111, 1'b1);
    wait_done();
    send(32'h1001_0000, 1'b0, 32'h55AA_55AA, 4'h3, 32'h2222_2222, 1'b1);
    wait_done();
    send(32'h1001_0002, 1'b1, 32'h0, 4'h0, 32'h3333_3333, 1'b1);
    wait_done();
    chk("illegal_no_dn_valid", cmd_valid_cyc, base);
    chk("err_cnt_3", err_cnt, exp_err_cnt);

    // Downstream and upstream backpressure.
    base = dn_cnt;
    slv_rdy_en = 1'b0;
    i_icb_rsp_ready = 1'b0;
    send(32'h1001_0010, 1'b1, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_dn_valid", o_icb_cmd_valid, 1'b1);
      chk("stall_dn_fields", {o_icb_cmd_addr, o_icb_cmd_read}, {12'h010, 1'b1});
      chk("stall_up_ready", i_icb_cmd_ready, 1'b0);
      tick();
    end
    slv_rdy_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rsp", {i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata}, {2'b10, 32'hCAFE_F00D});
      chk("hold_up_ready", i_icb_cmd_ready, 1'b0);
      tick();
    end
    i_icb_rsp_ready = 1'b1;
    wait_done();
    chk("stall_single_dn_hs", dn_cnt - base, 1);

    // Reset in the middle of an un-accepted downstream command.
    slv_rdy_en = 1'b0;
    send(32'h1001_0020, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("pre_rst_dn_valid", o_icb_cmd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dn_valid", o_icb_cmd_valid, 1'b0);
    chk("mid_rst_up_ready", i_icb_cmd_ready, 1'b1);
    chk("mid_rst_err_cnt", err_cnt, 0);
    up_q.delete();
    dn_q.delete();
    exp_err_cnt = 0;
    slv_rdy_en = 1'b1;
    tick();
    rst_n = 1'b1;
    base = dn_cnt;
    send(32'h1001_0ABC, 1'b1, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
    wait_done();
    chk("no_replay_dn_hs", dn_cnt - base, 1);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      send(32'h2000_0000 + 32'(i * 4), i[0], 32'h0, 4'h0, 32'(i), 1'b1);
      wait_done();
    end
    chk("err_cnt_sat", err_cnt, exp_err_cnt);

`ifdef E603_MISC_ICB_BUF_TMO_EN
    // Silent slave: timeout, then a stray response is dropped.
    slv_comb = 1'b0;
    send(32'h1001_0030, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1);
    dn_q.push_back({12'h030, 1'b1, 32'h0});
    n = 0;
    while (!i_icb_rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 8);
    wait_done();
    chk("drop_pend_rsp_ready", o_icb_rsp_ready, 1'b1);
    slv_stray = 1'b1;
    slv_rdata = 32'hBAD0_BAD0;
    tick();
    slv_stray = 1'b0;
    chk("drop_cleared", o_icb_rsp_ready, 1'b0);
    slv_comb = 1'b1;
    send(32'h1001_0040, 1'b1, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    wait_done();
    chk("tmo_err_cnt", err_cnt, exp_err_cnt);
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
